// File: rtl/mctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset controller.
// Consumers: mctrl_decode, multicycle_ctrl (perf counters gated by MCTRL_PERF_EN).
package mctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_RWB    = 4'd7,
    S_EXEC_I = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JR     = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  typedef enum logic [3:0] {
    CLS_R, CLS_JR, CLS_LW, CLS_SW, CLS_BR,
    CLS_IMM, CLS_LUI, CLS_J, CLS_JAL, CLS_ILL
  } cls_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] ALUB_REGB  = 2'd0;
  localparam logic [1:0] ALUB_FOUR  = 2'd1;
  localparam logic [1:0] ALUB_IMM   = 2'd2;
  localparam logic [1:0] ALUB_IMMSH = 2'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;
  localparam logic [1:0] M2R_LUI    = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REGA   = 2'd3;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;
  localparam logic [1:0] ALUOP_IMM   = 2'd3;

endpackage

// File: rtl/mctrl_decode.sv
// Combinational opcode/funct to instruction-class mapping.
module mctrl_decode
  import mctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_t       cls
);

  always_comb begin
    cls = CLS_ILL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_JR:                                    cls = CLS_JR;
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT:    cls = CLS_R;
          default:                                  cls = CLS_ILL;
        endcase
      end
      OP_LW:                                cls = CLS_LW;
      OP_SW:                                cls = CLS_SW;
      OP_BEQ, OP_BNE:                       cls = CLS_BR;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:    cls = CLS_IMM;
      OP_LUI:                               cls = CLS_LUI;
      OP_J:                                 cls = CLS_J;
      OP_JAL:                               cls = CLS_JAL;
      default:                              cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main controller FSM; define MCTRL_PERF_EN to add cycle/instret counters.
module multicycle_ctrl
  import mctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       iord,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic [3:0] state_o
`ifdef MCTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  state_t state, state_next;
  cls_t   cls;

  mctrl_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  assign state_o = state;

  // Memory handshake: an access is presented (mem_rd/mem_wr) for as long as
  // the FSM sits in FETCH/MEMRD/MEMWR; it completes on the edge where
  // mem_ready=1, and mem_ready is don't-care in every other state.
  always_comb begin
    state_next = state;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    iord       = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ALUB_REGB;
    reg_dst    = REGDST_RT;
    mem_to_reg = M2R_ALUOUT;
    pc_src     = PCSRC_ALU;
    alu_op     = ALUOP_ADD;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = ALUB_FOUR;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = ALUB_IMMSH;
        case (cls)
          CLS_R:           state_next = S_EXEC_R;
          CLS_JR:          state_next = S_JR;
          CLS_LW, CLS_SW:  state_next = S_MEMADR;
          CLS_BR:          state_next = S_BRANCH;
          CLS_IMM, CLS_LUI: state_next = S_EXEC_I;
          CLS_J, CLS_JAL:  state_next = S_JUMP;
          default:         state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = ALUB_IMM;
        state_next = (cls == CLS_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        reg_we     = 1'b1;
        mem_to_reg = M2R_MDR;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_FUNCT;
        state_next = S_RWB;
      end
      S_RWB: begin
        reg_we     = 1'b1;
        reg_dst    = REGDST_RD;
        state_next = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = ALUB_IMM;
        alu_op     = ALUOP_IMM;
        state_next = S_IWB;
      end
      S_IWB: begin
        reg_we     = 1'b1;
        mem_to_reg = (cls == CLS_LUI) ? M2R_LUI : M2R_ALUOUT;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_SUB;
        pc_src     = PCSRC_ALUOUT;
        pc_we      = (opcode == OP_BNE) ? ~zero : zero;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        pc_src = PCSRC_JUMP;
        pc_we  = 1'b1;
        if (cls == CLS_JAL) begin
          reg_we     = 1'b1;
          reg_dst    = REGDST_RA;
          mem_to_reg = M2R_PC;
        end
        state_next = S_FETCH;
      end
      S_JR: begin
        pc_src     = PCSRC_REGA;
        pc_we      = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: state_next = S_TRAP;
    endcase

    // Reset abandons any in-flight access and suppresses every strobe.
    if (rst) begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      reg_we     = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      iord       = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = ALUB_REGB;
      reg_dst    = REGDST_RT;
      mem_to_reg = M2R_ALUOUT;
      pc_src     = PCSRC_ALU;
      alu_op     = ALUOP_ADD;
      illegal    = 1'b0;
    end
  end

`ifdef MCTRL_PERF_EN
  // An instruction retires when a non-FETCH, non-TRAP state hands back to FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (state != S_FETCH && state != S_TRAP && state_next == S_FETCH)
        instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle main controller for the 32-bit MIPS-subset CPU. It is a registered-state FSM that sequences one instruction over 3–5+ cycles. Each cycle it drives the write enables and the select inputs of the datapath's 2:1/4:1 32-bit and 4:1 5-bit multiplexers. It sits beside the datapath, takes opcode/funct from the instruction register plus ALU zero, and handshakes with unified instruction/data memory via `mem_ready`.

## Interface
- No parameters.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `opcode` in 6 — IR[31:26], stable from DECODE onward.
- `funct` in 6 — IR[5:0].
- `zero` in 1 — ALU zero flag, valid in BRANCH.
- `mem_ready` in 1 — memory completes the current access this cycle.
- `pc_we`, `ir_we`, `reg_we`, `mem_rd`, `mem_wr` out 1 — enables.
- `iord` out 1 — memory address mux: 0 PC, 1 ALUOut.
- `alu_src_a` out 1 — 0 PC, 1 reg A.
- `alu_src_b` out 2 — 0 reg B, 1 const 4, 2 sign-ext imm, 3 sign-ext imm<<2.
- `reg_dst` out 2 — 0 rt, 1 rd, 2 const 31, 3 reserved (never driven).
- `mem_to_reg` out 2 — 0 ALUOut, 1 MDR, 2 PC (link), 3 imm<<16 (lui).
- `pc_src` out 2 — 0 ALU result, 1 ALUOut, 2 jump target, 3 reg A.
- `alu_op` out 2 — 0 add, 1 sub, 2 funct-decoded, 3 opcode-decoded immediate op.
- `illegal` out 1 — sticky, unsupported opcode/funct decoded.
- `state_o` out 4 — current state encoding, for debug.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, RWB, EXEC_I, IWB, BRANCH, JUMP, JR, TRAP.
- FETCH:
  - Drives `mem_rd`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=0, `pc_src`=0.
  - `ir_we` and `pc_we` equal `mem_ready` (Mealy).
  - Stays in FETCH while `mem_ready`=0; moves to DECODE on `mem_ready`=1.
- DECODE: `alu_src_a`=0, `alu_src_b`=3, `alu_op`=0 (branch target into ALUOut). Next state by opcode:
  - 0x00: JR if funct=0x08; EXEC_R for add/sub/and/or/slt (0x20, 0x22, 0x24, 0x25, 0x2A); otherwise TRAP.
  - 0x23 (lw), 0x2B (sw): MEMADR.
  - 0x04 (beq), 0x05 (bne): BRANCH.
  - 0x08, 0x0A, 0x0C, 0x0D, 0x0F: EXEC_I.
  - 0x02 (j), 0x03 (jal): JUMP.
  - Anything else: TRAP.
- MEMADR: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=0. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: `mem_rd`=1, `iord`=1. Waits for `mem_ready`, then MEMWB.
- MEMWB: `reg_we`=1, `reg_dst`=0, `mem_to_reg`=1. Then FETCH.
- MEMWR: `mem_wr`=1, `iord`=1. Waits for `mem_ready`, then FETCH.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=2. Then RWB.
- RWB: `reg_we`=1, `reg_dst`=1, `mem_to_reg`=0. Then FETCH.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=3. Then IWB.
- IWB: `reg_we`=1, `reg_dst`=0. `mem_to_reg`=3 for lui, else 0. Then FETCH.
- BRANCH:
  - `alu_src_a`=1, `alu_src_b`=0, `alu_op`=1, `pc_src`=1.
  - `pc_we` = `zero` for beq, `~zero` for bne.
  - Then FETCH.
- JUMP: `pc_src`=2, `pc_we`=1. For jal, also `reg_we`=1, `reg_dst`=2, `mem_to_reg`=2 (PC already incremented). Then FETCH.
- JR: `pc_src`=3, `pc_we`=1. Then FETCH.
- TRAP: all enables 0 and `illegal`=1. Stays in TRAP until `rst`.
- Outputs not listed for a state are 0.

## Timing
- Zero-wait latencies (cycles):
  - lw 5; sw 4; R-type 4; I-type 4.
  - beq/bne 3; j/jal/jr 3.
- Each memory wait cycle adds 1 cycle in FETCH, MEMRD or MEMWR.
- `mem_ready` is sampled only in FETCH, MEMRD and MEMWR; it is ignored elsewhere.
- Write enables are combinational from the registered state. The datapath captures on the same edge that leaves the state.
- Reset:
  - While `rst`=1, all enables and selects are forced to 0 and `illegal`=0.
  - The first edge with `rst`=1 sets the state to FETCH.
  - Reset mid-access abandons the access; no write is issued in the reset cycle.

## Configuration
- `MCTRL_PERF_EN` defined:
  - Adds outputs `cycle_cnt` (32 bits) and `instret_cnt` (32 bits), both reset to 0.
  - `cycle_cnt` increments every non-reset cycle and wraps.
  - `instret_cnt` increments on every transition into FETCH from a non-FETCH, non-TRAP state.
- `MCTRL_PERF_EN` undefined: those ports and counters are absent.

## Structure
- `mctrl_pkg` holds:
  - The state enum.
  - Opcode and funct constants.
  - Select encodings: `ALUB_*`, `REGDST_*`, `M2R_*`, `PCSRC_*`, `ALUOP_*`.
- Sub-module `mctrl_decode`: combinational mapping of opcode/funct to an instruction class (R, JR, LW, SW, BR, IMM, LUI, J, JAL, ILL).

## Test plan
- `lw` (op 0x23) with `mem_ready` tied high → states FETCH, DECODE, MEMADR, MEMRD, MEMWB; `reg_we`=1 with `mem_to_reg`=1 exactly in cycle 5.
- FETCH with `mem_ready` low for 3 cycles → `ir_we` and `pc_we` stay 0 for 3 cycles, then pulse 1 in cycle 4 only.
- beq with `zero`=1, then bne with `zero`=1 → `pc_we`=1 in BRANCH, then 0 in BRANCH; `pc_src`=1 both times.
- jal (op 0x03) → JUMP cycle drives `reg_dst`=2, `mem_to_reg`=2, `reg_we`=1, `pc_src`=2.
- op 0x3F → TRAP, `illegal`=1, no enables for 20 cycles; `rst` pulse → FETCH, `illegal`=0.
- `rst` asserted during MEMWR with `mem_ready`=1 → `mem_wr`=0 that cycle, state FETCH next; with `MCTRL_PERF_EN`, `instret_cnt` counts 4 after 4 zero-wait add instructions.
